attack_resolver: RTL and testbench



---
 rtl/attack_resolver.sv | 154 +++++++++++++++
 tb/tb_attack_resolver.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_resolver.sv
// Resolves one attack or special-move button press into a single strike
// (dodge roll, crit, meter gating, speed-scaled cooldown) for the stat blocks.
module attack_resolver #(
   parameter logic [5:0]  BASE_DMG      = 6'd10,
   parameter logic [5:0]  SPECIAL_DMG   = 6'd30,
   parameter logic [2:0]  SPECIAL_COST  = 3'd3,
   parameter int unsigned COOLDOWN_BASE = 4,
   parameter bit          CRIT_EN       = 1'b1,
   parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_attack,
   input  logic       btn_special,
   input  logic [2:0] atk_speed,
   input  logic [4:0] atk_special,
   input  logic [2:0] def_dodge,
   output logic [5:0] damage,
   output logic [2:0] cost,
   output logic       en,
   output logic       update,
   output logic       busy,
   output logic       crit,
   output logic       denied
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ROLL  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_APPLY = 3'd3;
   localparam logic [2:0] S_COOL  = 3'd4;

   logic [2:0] state_q, state_d;
   logic       prev_atk_q, prev_spc_q;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] cool_q, cool_d;
   logic       is_special_q, is_special_d;
   logic [5:0] damage_q, damage_d;
   logic [2:0] cost_q, cost_d;
   logic       en_q, en_d;
   logic       crit_q, crit_d;
   logic       update_q, update_d;
   logic       busy_q, busy_d;
   logic       denied_q, denied_d;

   logic       atk_edge, spc_edge, meter_ok, dodged, atk_crit;
   logic [5:0] atk_sum, atk_dmg, spc_dmg;
   logic [7:0] cool_prod, cool_load;

   function automatic logic [5:0] sat63(input logic [6:0] v);
      return v[6] ? 6'd63 : v[5:0];
   endfunction

   always_comb begin
      atk_edge  = btn_attack & ~prev_atk_q;
      spc_edge  = btn_special & ~prev_spc_q;
      meter_ok  = (atk_special >= {2'b00, SPECIAL_COST});
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      // Saturate the base sum before doubling so the 7-bit intermediate cannot wrap.
      atk_sum   = sat63({1'b0, BASE_DMG} + {4'b0000, atk_speed});
      atk_crit  = CRIT_EN && (lfsr_q[7:5] == 3'b111);
      atk_dmg   = atk_crit ? sat63({atk_sum, 1'b0}) : atk_sum;
      spc_dmg   = sat63({1'b0, SPECIAL_DMG} + {3'b000, atk_speed, 1'b0});
      dodged    = !is_special_q && (lfsr_q[3:0] < {1'b0, def_dodge});
      cool_prod = 8'(COOLDOWN_BASE * (32'd8 - 32'(atk_speed)));
      cool_load = (cool_prod == 8'd0) ? 8'd1 : cool_prod;
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      is_special_d = is_special_q;
      cool_d       = cool_q;
      damage_d     = damage_q;
      cost_d       = cost_q;
      en_d         = en_q;
      crit_d       = crit_q;
      denied_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            denied_d = spc_edge && !meter_ok;
            if (spc_edge && meter_ok) begin
               state_d      = S_ROLL;
               is_special_d = 1'b1;
            end else if (atk_edge) begin
               state_d      = S_ROLL;
               is_special_d = 1'b0;
            end
         end
         S_ROLL: begin
            state_d = S_SETUP;
            cool_d  = cool_load;
            if (is_special_q) begin
               {damage_d, cost_d, en_d, crit_d} = {spc_dmg, SPECIAL_COST, 1'b1, 1'b0};
            end else if (dodged) begin
               {damage_d, cost_d, en_d, crit_d} = {6'd0, 3'd0, 1'b0, 1'b0};
            end else begin
               {damage_d, cost_d, en_d, crit_d} = {atk_dmg, 3'd0, 1'b1, atk_crit};
            end
         end
         S_SETUP: state_d = S_APPLY;
         S_APPLY: state_d = S_COOL;
         S_COOL: begin
            if (cool_q <= 8'd1) state_d = S_IDLE;
            else                cool_d  = cool_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
      update_d = (state_q == S_SETUP);
      busy_d   = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         prev_atk_q   <= 1'b1;
         prev_spc_q   <= 1'b1;
         lfsr_q       <= LFSR_SEED;
         cool_q       <= 8'd0;
         is_special_q <= 1'b0;
         damage_q     <= 6'd0;
         cost_q       <= 3'd0;
         en_q         <= 1'b0;
         crit_q       <= 1'b0;
         update_q     <= 1'b0;
         busy_q       <= 1'b0;
         denied_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_atk_q   <= btn_attack;
         prev_spc_q   <= btn_special;
         lfsr_q       <= lfsr_d;
         cool_q       <= cool_d;
         is_special_q <= is_special_d;
         damage_q     <= damage_d;
         cost_q       <= cost_d;
         en_q         <= en_d;
         crit_q       <= crit_d;
         update_q     <= update_d;
         busy_q       <= busy_d;
         denied_q     <= denied_d;
      end
   end

   assign damage = damage_q;
   assign cost   = cost_q;
   assign en     = en_q;
   assign crit   = crit_q;
   assign update = update_q;
   assign busy   = busy_q;
   assign denied = denied_q;

endmodule

// File: tb/tb_attack_resolver.sv
// Bench for attack_resolver: three parameterisations share one stimulus stream and
// are checked every cycle against a timeline-based model, plus literal spot checks.
module tb_attack_resolver;

   localparam int NEVER = 32'h3fff_ffff;

   logic       clk = 1'b0;
   logic       rst, btn_attack, btn_special;
   logic [2:0] atk_speed, def_dodge;
   logic [4:0] atk_special;

   logic [5:0] damage_o [3];
   logic [2:0] cost_o   [3];
   logic       en_o     [3];
   logic       update_o [3];
   logic       busy_o   [3];
   logic       crit_o   [3];
   logic       denied_o [3];

   always #5 clk = ~clk;

   // Instance 0: defaults; 1: crits disabled; 2: BASE_DMG = 40 to reach saturation.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      attack_resolver #(
         .BASE_DMG (g == 2 ? 6'd40 : 6'd10),
         .CRIT_EN  (g == 1 ? 1'b0 : 1'b1)
      ) dut (
         .clk         (clk),
         .rst         (rst),
         .btn_attack  (btn_attack),
         .btn_special (btn_special),
         .atk_speed   (atk_speed),
         .atk_special (atk_special),
         .def_dodge   (def_dodge),
         .damage      (damage_o[g]),
         .cost        (cost_o[g]),
         .en          (en_o[g]),
         .update      (update_o[g]),
         .busy        (busy_o[g]),
         .crit        (crit_o[g]),
         .denied      (denied_o[g])
      );
   end

   int n_cmp = 0;
   int n_mis = 0;

   // Model state: strike described by its edge cycle and first idle cycle.
   int         now = 0;
   bit         m_valid = 1'b0;
   bit         m_active, m_prev_a, m_prev_s, m_special;
   int         m_t_edge, m_t_end;
   logic [7:0] m_lfsr;
   int         e_dmg [3];
   bit         e_crit [3];
   int         e_cost;
   bit         e_en, e_upd, e_busy, e_den;

   function automatic int min63(input int v);
      return (v > 63) ? 63 : v;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic int model_dmg(input int base, input bit crit_en, input bit special,
                                    input int speed, input int lf, input int dodge,
                                    output bit crit);
      int d;
      crit = 1'b0;
      if (special) return min63(30 + 2 * speed);
      if ((lf % 16) < dodge) return 0;
      d = min63(base + speed);
      if (crit_en && (lf / 32) == 7) begin
         crit = 1'b1;
         d    = min63(2 * d);
      end
      return d;
   endfunction

   // Predicts the outputs of the next cycle from the inputs about to be sampled.
   task automatic model_step();
      bit idle, ae, se, ok, c, hit;
      int cd;
      if (rst) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_prev_a = 1'b1;
         m_prev_s = 1'b1;
         m_lfsr   = 8'hA5;
         for (int i = 0; i < 3; i++) begin
            e_dmg[i]  = 0;
            e_crit[i] = 1'b0;
         end
         e_cost = 0;
         {e_en, e_upd, e_busy, e_den} = 4'b0000;
      end else if (m_valid) begin
         idle = !m_active || (now >= m_t_end);
         if (idle) m_active = 1'b0;
         ae    = btn_attack && !m_prev_a;
         se    = btn_special && !m_prev_s;
         ok    = (int'(atk_special) >= 3);
         e_den = idle && se && !ok;
         if (idle && ((se && ok) || ae)) begin
            m_active  = 1'b1;
            m_special = se && ok;
            m_t_edge  = now;
            m_t_end   = NEVER;
         end else if (m_active && now == m_t_edge + 1) begin
            for (int i = 0; i < 3; i++) begin
               e_dmg[i]  = model_dmg(i == 2 ? 40 : 10, i != 1, m_special, int'(atk_speed),
                                     int'(m_lfsr), int'(def_dodge), c);
               e_crit[i] = c;
            end
            hit    = m_special || ((int'(m_lfsr) % 16) >= int'(def_dodge));
            e_en   = hit;
            e_cost = (m_special && hit) ? 3 : 0;
            cd     = (4 * (8 - int'(atk_speed))) % 256;
            if (cd == 0) cd = 1;
            m_t_end = m_t_edge + 4 + cd;
         end
         e_upd    = m_active && (now + 1 == m_t_edge + 3);
         e_busy   = m_active && (now + 1 < m_t_end);
         m_prev_a = btn_attack;
         m_prev_s = btn_special;
         m_lfsr   = lfsr_next(m_lfsr);
      end
      now++;
   endtask

   task automatic compare_all();
      logic [13:0] got, want;
      if (!m_valid) return;
      for (int i = 0; i < 3; i++) begin
         got  = {damage_o[i], cost_o[i], en_o[i], update_o[i], busy_o[i], crit_o[i], denied_o[i]};
         want = {6'(e_dmg[i]), 3'(e_cost), e_en, e_upd, e_busy, e_crit[i], e_den};
         n_cmp++;
         if (got !== want) begin
            n_mis++;
            $display("FAIL cycle%0d_dut%0d: got dmg=%0d cost=%0d en=%0d upd=%0d busy=%0d crit=%0d den=%0d, want dmg=%0d cost=%0d en=%0d upd=%0d busy=%0d crit=%0d den=%0d",
                     now, i, got[13:8], got[7:5], got[4], got[3], got[2], got[1], got[0],
                     want[13:8], want[7:5], want[4], want[3], want[2], want[1], want[0]);
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic wait_update(input string name);
      int n = 0;
      while (update_o[0] !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      check(name, 32'(update_o[0]), 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy_o[0] !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      check(name, 32'(busy_o[0]), 0);
   endtask

   initial begin
      int lat, cnt, seen, misses, crits;
      rst = 1'b1; btn_attack = 1'b1; btn_special = 1'b0;
      atk_speed = 3'd4; atk_special = 5'd0; def_dodge = 3'd0;
      repeat (3) tick();
      check("rst_damage", 32'(damage_o[0]), 0);
      check("rst_busy",   32'(busy_o[0]),   0);
      check("rst_update", 32'(update_o[0]), 0);

      // Button held through reset must not fire.
      rst = 1'b0;
      repeat (5) tick();
      check("held_btn_no_strike", 32'(busy_o[0]), 0);

      btn_attack = 1'b0; tick();
      btn_attack = 1'b1; tick();
      lat = 1;
      while (update_o[0] !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("edge_to_update", lat, 3);
      check("basic_dmg",  32'(damage_o[1]), 14);
      check("basic_en",   32'(en_o[1]),     1);
      check("basic_cost", 32'(cost_o[1]),   0);
      btn_attack = 1'b0;
      cnt = 3;
      tick();
      while (busy_o[1] === 1'b1 && cnt < 100) begin
         cnt++;
         tick();
      end
      check("basic_busy_len", cnt, 19);

      // Special with enough meter.
      atk_special = 5'd5; atk_speed = 3'd7;
      btn_special = 1'b1; tick(); btn_special = 1'b0;
      wait_update("special_update");
      check("special_dmg",  32'(damage_o[0]), 44);
      check("special_cost", 32'(cost_o[0]),   3);
      check("special_en",   32'(en_o[0]),     1);
      check("special_crit", 32'(crit_o[0]),   0);
      wait_idle("special_idle");

      // Special without enough meter.
      atk_special = 5'd2; atk_speed = 3'd4;
      btn_special = 1'b1; tick();
      check("denied_pulse", 32'(denied_o[0]), 1);
      btn_special = 1'b0; tick();
      check("denied_one_cycle", 32'(denied_o[0]), 0);
      seen = 0;
      repeat (8) begin
         tick();
         if (update_o[0] === 1'b1 || busy_o[0] === 1'b1) seen++;
      end
      check("denied_no_strike", seen, 0);

      // Rejected special with a simultaneous attack resolves as the attack.
      btn_special = 1'b1; btn_attack = 1'b1; tick();
      btn_special = 1'b0; btn_attack = 1'b0;
      wait_update("combo_update");
      check("combo_cost", 32'(cost_o[1]),   0);
      check("combo_dmg",  32'(damage_o[1]), 14);
      check("combo_en",   32'(en_o[1]),     1);
      wait_idle("combo_idle");

      // A press during cooldown is dropped.
      btn_attack = 1'b1; tick(); btn_attack = 1'b0;
      wait_update("cool_update");
      repeat (3) tick();
      btn_attack = 1'b1; tick(); btn_attack = 1'b0; tick();
      wait_idle("cool_idle");
      repeat (5) tick();
      check("cool_press_dropped", 32'(busy_o[0]), 0);

      // Reset in SETUP aborts the strike.
      btn_attack = 1'b1; tick(); btn_attack = 1'b0; tick();
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_busy",   32'(busy_o[0]),   0);
      check("midrst_update", 32'(update_o[0]), 0);
      check("midrst_damage", 32'(damage_o[0]), 0);
      check("midrst_en",     32'(en_o[0]),     0);
      seen = 0;
      repeat (6) begin
         tick();
         if (update_o[0] === 1'b1) seen++;
      end
      check("midrst_no_update", seen, 0);

      // 200 attacks against a high dodge stat.
      misses = 0; crits = 0;
      def_dodge = 3'd7;
      for (int k = 0; k < 200; k++) begin
         atk_speed   = 3'($urandom_range(0, 7));
         atk_special = 5'($urandom_range(0, 31));
         btn_attack = 1'b1; tick(); btn_attack = 1'b0;
         wait_update("rand_update");
         if (en_o[0] === 1'b0) misses++;
         if (crit_o[2] === 1'b1) begin
            crits++;
            check("crit_saturates", 32'(damage_o[2]), 63);
         end
         wait_idle("rand_idle");
      end
      check("misses_seen", 32'(misses > 0), 1);

      // Free-running random inputs, including occasional reset.
      for (int k = 0; k < 1500; k++) begin
         btn_attack  = 1'($urandom_range(0, 1));
         btn_special = 1'($urandom_range(0, 1));
         atk_speed   = 3'($urandom_range(0, 7));
         atk_special = 5'($urandom_range(0, 31));
         def_dodge   = 3'($urandom_range(0, 7));
         rst         = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
